// File: rtl/data_memory.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_memory: RV64 data-side responder; sized/extended loads, byte-masked
// stores, fixed LATENCY valid/ready response. Option macro: DMEM_MISALIGN_TRAP_EN
// Revision: 1.0
// ----------------------------------------------------------------------------
module data_memory #(
    parameter int DEPTH_WORDS = 512,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [63:0] Address,
    input  logic [63:0] Write_data,
    output logic [63:0] Read_data,
    output logic        resp_valid,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] c_wait_last = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [63:0]    pend_data_q;
    logic           pend_err_q;
    logic           resp_valid_q;
    logic           err_q;
    logic [63:0]    rdata_q;

    logic [63:0]    mem_q [DEPTH_WORDS];

    logic [AW-1:0]  idx;
    logic [1:0]     size;
    logic [2:0]     off_raw;
    logic [2:0]     align_mask;
    logic [2:0]     off;
    logic           reject;
    logic           accept;
    logic [7:0]     byte_en;
    logic [7:0]     be_sh;
    logic [63:0]    bit_mask;
    logic [63:0]    wdata_sh;
    logic [63:0]    word;
    logic [63:0]    shifted;
    logic [63:0]    load_val;
    logic [63:0]    merged_d;
    logic [63:0]    resp_data_d;
    logic           unused_addr_bits;

    assign idx              = Address[AW+2:3];
    assign unused_addr_bits = ^Address[63:AW+3];
    assign size             = funct3[1:0];
    assign off_raw          = Address[2:0];

    always_comb begin
        align_mask = 3'b000;
        byte_en    = 8'hFF;
        case (size)
            2'b00:   begin align_mask = 3'b111; byte_en = 8'h01; end
            2'b01:   begin align_mask = 3'b110; byte_en = 8'h03; end
            2'b10:   begin align_mask = 3'b100; byte_en = 8'h0F; end
            default: begin align_mask = 3'b000; byte_en = 8'hFF; end
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign reject = |(off_raw & ~align_mask);
    assign off    = off_raw;
`else
    assign reject = 1'b0;
    assign off    = off_raw & align_mask;
`endif

    assign req_ready = (state_q != WAIT) & ~reset;
    assign accept    = req_valid & req_ready & (MemRead | MemWrite);

    assign word     = mem_q[idx];
    assign shifted  = word >> {off, 3'b000};
    assign wdata_sh = Write_data << {off, 3'b000};
    // Offset is always naturally aligned whenever the lane mask is used.
    assign be_sh    = byte_en << off;

    always_comb begin
        bit_mask = '0;
        for (int b = 0; b < 8; b++) begin
            bit_mask[b*8 +: 8] = {8{be_sh[b]}};
        end
    end

    assign merged_d = (word & ~bit_mask) | (wdata_sh & bit_mask);

    always_comb begin
        load_val = shifted;
        case (size)
            2'b00:   load_val = funct3[2] ? {56'd0, shifted[7:0]}
                                          : {{56{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = funct3[2] ? {48'd0, shifted[15:0]}
                                          : {{48{shifted[15]}}, shifted[15:0]};
            2'b10:   load_val = funct3[2] ? {32'd0, shifted[31:0]}
                                          : {{32{shifted[31]}}, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    // Stores (including MemRead&MemWrite) and rejected accesses return zero.
    assign resp_data_d = (MemWrite || reject) ? 64'd0 : load_val;

    always_ff @(posedge clk) begin
        if (accept && MemWrite && !reject) begin
            mem_q[idx] <= merged_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pend_data_q  <= '0;
            pend_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            case (state_q)
                IDLE, RESP: begin
                    if (accept) begin
                        if (LATENCY == 1) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            err_q        <= reject;
                            rdata_q      <= resp_data_d;
                        end else begin
                            state_q     <= WAIT;
                            cnt_q       <= '0;
                            pend_data_q <= resp_data_d;
                            pend_err_q  <= reject;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_q == c_wait_last) begin
                        state_q      <= RESP;
                        cnt_q        <= '0;
                        resp_valid_q <= 1'b1;
                        err_q        <= pend_err_q;
                        rdata_q      <= pend_data_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign err        = err_q;
    assign Read_data  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// tb_data_memory: scoreboard bench for data_memory with default parameters.
module tb_data_memory;
    localparam int DEPTH_WORDS = 512;
    localparam int LATENCY     = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [63:0] Address;
    logic [63:0] Write_data;
    logic [63:0] Read_data;
    logic        resp_valid;
    logic        err;

    data_memory #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3), .Address(Address),
        .Write_data(Write_data), .Read_data(Read_data), .resp_valid(resp_valid),
        .err(err)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_q[$];
    logic [63:0] obs_d_q[$];
    logic        obs_e_q[$];
    int          obs_c_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            obs_d_q.push_back(Read_data);
            obs_e_q.push_back(err);
            obs_c_q.push_back(cycle);
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] exp_data, input logic exp_err, input bit keep);
        bit done = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        MemRead    = rd;
        MemWrite   = wr;
        funct3     = f3;
        Address    = addr;
        Write_data = wdata;
        for (int w = 0; w < 20 && !done; w++) begin
            if (req_ready === 1'b1) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept: addr=%h got no acceptance want acceptance within 20 cycles", addr);
        end else begin
            exp_q.push_back('{exp_data, exp_err});
            acc_q.push_back(cycle);
        end
        if (!keep) begin
            req_valid  = 1'b0;
            MemRead    = 1'($urandom);
            MemWrite   = 1'($urandom);
            funct3     = 3'($urandom);
            Address    = {$urandom, $urandom};
            Write_data = {$urandom, $urandom};
        end
    endtask

    task automatic wait_resp(output logic [63:0] d, output logic e, output int c, output bit ok);
        ok = 1'b0;
        d  = '0;
        e  = 1'b0;
        c  = 0;
        for (int i = 0; i < 20 && obs_d_q.size() == 0; i++) begin
            @(negedge clk);
            #2;
        end
        if (obs_d_q.size() != 0) begin
            d  = obs_d_q.pop_front();
            e  = obs_e_q.pop_front();
            c  = obs_c_q.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        funct3 = 3'd0; Address = '0; Write_data = '0;
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
        n_cmp++; if (Read_data !== 64'd0) begin n_bad++; $display("FAIL rst_data: got %h want 0", Read_data); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
    endtask

    // Pops every outstanding expectation and checks data, err and latency.
    task automatic test_store_load;
        exp_t ex; int ac; logic [63:0] d; logic e; int c; bit ok;
        issue(1'b0, 1'b1, 3'b011, 64'h10, 64'h8877_6655_4433_2211, 64'd0, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 64'h8877_6655_4433_2211, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); ac = acc_q.pop_front();
            wait_resp(d, e, c, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL sd_ld: got no response want data=%h err=%b", ex.data, ex.err); end
            else if (d !== ex.data || e !== ex.err) begin
                n_bad++; $display("FAIL sd_ld: got data=%h err=%b want data=%h err=%b", d, e, ex.data, ex.err);
            end
            // Response is visible after edge (accept + LATENCY - 1).
            if (ok) begin
                n_cmp++;
                if (c - ac !== LATENCY - 1) begin n_bad++; $display("FAIL sd_ld_latency: got %0d want %0d", c - ac, LATENCY - 1); end
            end
        end
    endtask

    task automatic test_sizes;
        exp_t ex; logic [63:0] d; logic e; int c; bit ok;
        issue(1'b1, 1'b0, 3'b000, 64'h17, 64'd0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b100, 64'h17, 64'd0, 64'h88, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b001, 64'h12, 64'd0, 64'h4433, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b110, 64'h14, 64'd0, 64'h8877_6655, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b010, 64'h14, 64'd0, 64'hFFFF_FFFF_8877_6655, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b101, 64'h16, 64'd0, 64'h8877, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b001, 64'h16, 64'd0, 64'hFFFF_FFFF_FFFF_8877, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b111, 64'h10, 64'd0, 64'h8877_6655_4433_2211, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); void'(acc_q.pop_front());
            wait_resp(d, e, c, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL sizes: got no response want data=%h", ex.data); end
            else if (d !== ex.data || e !== ex.err) begin
                n_bad++; $display("FAIL sizes: got data=%h err=%b want data=%h err=%b", d, e, ex.data, ex.err);
            end
        end
    endtask

    task automatic test_byte_store;
        exp_t ex; logic [63:0] d; logic e; int c; bit ok;
        issue(1'b0, 1'b1, 3'b000, 64'h11, 64'h1234_5678_9ABC_DEAB, 64'd0, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 64'h8877_6655_4433_AB11, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'b011, 64'h18, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'b001, 64'h1C, 64'hAAAA_AAAA_AAAA_1234, 64'd0, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b011, 64'h18, 64'd0, 64'hFFFF_1234_FFFF_FFFF, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); void'(acc_q.pop_front());
            wait_resp(d, e, c, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL byte_store: got no response want data=%h", ex.data); end
            else if (d !== ex.data || e !== ex.err) begin
                n_bad++; $display("FAIL byte_store: got data=%h err=%b want data=%h err=%b", d, e, ex.data, ex.err);
            end
        end
    endtask

    task automatic test_wrap_and_rw;
        exp_t ex; logic [63:0] d; logic e; int c; bit ok;
        issue(1'b0, 1'b1, 3'b011, 64'h0, 64'h1, 64'd0, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b011, 64'(DEPTH_WORDS * 8), 64'd0, 64'h1, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 3'b011, 64'h20, 64'h55, 64'd0, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b011, 64'h20, 64'd0, 64'h55, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); void'(acc_q.pop_front());
            wait_resp(d, e, c, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL wrap_rw: got no response want data=%h", ex.data); end
            else if (d !== ex.data || e !== ex.err) begin
                n_bad++; $display("FAIL wrap_rw: got data=%h err=%b want data=%h err=%b", d, e, ex.data, ex.err);
            end
        end
        // req_valid with neither MemRead nor MemWrite must be ignored.
        @(negedge clk);
        req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = 64'h10;
        repeat (4) @(negedge clk);
        #2;
        n_cmp++; if (obs_d_q.size() != 0) begin n_bad++; $display("FAIL ignored_req: got %0d responses want 0", obs_d_q.size()); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ignored_ready: got %b want 1", req_ready); end
        n_cmp++; if (Read_data !== 64'd0) begin n_bad++; $display("FAIL idle_data: got %h want 0", Read_data); end
        req_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        exp_t ex; logic [63:0] d; logic e; int c; bit ok; int prev; bit first;
        logic [63:0] addrs [4];
        logic [2:0]  f3s   [4];
        logic [63:0] vals  [4];
        addrs = '{64'h10, 64'h18, 64'h1000, 64'h20};
        f3s   = '{3'b011, 3'b011, 3'b011, 3'b100};
        vals  = '{64'h8877_6655_4433_AB11, 64'hFFFF_1234_FFFF_FFFF, 64'h1, 64'h55};
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b0, f3s[i], addrs[i], 64'd0, vals[i], 1'b0, (i < 3));
            n_cmp++;
            if (req_ready !== ((LATENCY > 1) ? 1'b0 : 1'b1)) begin
                n_bad++; $display("FAIL b2b_ready_wait: got %b want %b", req_ready, (LATENCY > 1) ? 1'b0 : 1'b1);
            end
        end
        first = 1'b1; prev = 0;
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); void'(acc_q.pop_front());
            wait_resp(d, e, c, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL b2b: got no response want data=%h", ex.data); end
            else if (d !== ex.data || e !== ex.err) begin
                n_bad++; $display("FAIL b2b: got data=%h err=%b want data=%h err=%b", d, e, ex.data, ex.err);
            end
            if (ok && !first) begin
                n_cmp++;
                if (c - prev !== LATENCY) begin n_bad++; $display("FAIL b2b_spacing: got %0d want %0d", c - prev, LATENCY); end
            end
            if (ok) begin prev = c; first = 1'b0; end
        end
    endtask

    task automatic test_reset_mid;
        exp_t ex; logic [63:0] d; logic e; int c; bit ok;
        issue(1'b0, 1'b1, 3'b011, 64'h28, 64'h77, 64'd0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        exp_q.delete(exp_q.size() - 1);
        acc_q.delete(acc_q.size() - 1);
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b want 0", req_ready); end
        repeat (3) @(negedge clk);
        #2;
        n_cmp++; if (obs_d_q.size() != 0) begin n_bad++; $display("FAIL midrst_dropped: got %0d responses want 0", obs_d_q.size()); end
        n_cmp++; if (resp_valid !== 1'b0 || Read_data !== 64'd0) begin
            n_bad++; $display("FAIL midrst_outputs: got valid=%b data=%h want valid=0 data=0", resp_valid, Read_data);
        end
        reset = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_release: got %b want 1", req_ready); end
        issue(1'b1, 1'b0, 3'b011, 64'h28, 64'd0, 64'h77, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); void'(acc_q.pop_front());
            wait_resp(d, e, c, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL midrst_commit: got no response want data=%h", ex.data); end
            else if (d !== ex.data || e !== ex.err) begin
                n_bad++; $display("FAIL midrst_commit: got data=%h err=%b want data=%h err=%b", d, e, ex.data, ex.err);
            end
        end
    endtask

    task automatic test_misalign;
        exp_t ex; logic [63:0] d; logic e; int c; bit ok;
        issue(1'b1, 1'b0, 3'b010, 64'h12, 64'd0,
              TRAP ? 64'd0 : 64'h0000_0000_4433_AB11, TRAP, 1'b0);
        issue(1'b0, 1'b1, 3'b001, 64'h13, 64'h0000_0000_0000_BEEF, 64'd0, TRAP, 1'b0);
        issue(1'b1, 1'b0, 3'b011, 64'h10, 64'd0,
              TRAP ? 64'h8877_6655_4433_AB11 : 64'h8877_6655_BEEF_AB11, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); void'(acc_q.pop_front());
            wait_resp(d, e, c, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL misalign: got no response want data=%h err=%b", ex.data, ex.err); end
            else if (d !== ex.data || e !== ex.err) begin
                n_bad++; $display("FAIL misalign: got data=%h err=%b want data=%h err=%b", d, e, ex.data, ex.err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_sizes();
        test_byte_store();
        test_wrap_and_rw();
        test_back_to_back();
        test_reset_mid();
        test_misalign();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
